// File: rtl/edge_latency_pkg.sv
// Shared types and helpers for the edge latency meter.
// Defines the per-channel edge mode and FSM state encodings.
package edge_latency_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_ANY  = 2'b10,
        MODE_RSVD = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_DONE  = 2'b10
    } ch_state_t;

    // Decide whether the detected rise/fall qualifies under the latched mode.
    // The reserved encoding behaves like "any edge".
    function automatic logic edgeHit(edge_mode_t mode, logic riseHit, logic fallHit);
        case (mode)
            MODE_RISE: return riseHit;
            MODE_FALL: return fallHit;
            default:   return riseHit | fallHit;
        endcase
    endfunction

endpackage

// File: rtl/edge_latency_ch.sv
// One channel of the edge latency meter.
// Arms on a kick, counts cycles until a qualifying edge or a timeout,
// then holds the result until acknowledged.
module edge_latency_ch
    import edge_latency_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic             kick_i,
    input  logic [1:0]       mode_i,
    input  logic             ack_i,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] meas_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ch_state_t        state_q, state_d;
    edge_mode_t       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             ovf_q, ovf_d;
    logic             sig_q;

    logic             riseHit;
    logic             fallHit;
    logic             edgeSeen;
    logic [CNT_W-1:0] cntInc;

    // Edge detection against the previous sample, plus next-state decoding.
    // A count that would reach all ones is reported as a timeout even if an
    // edge shows up in that same cycle, so all ones never means a real delay.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        meas_d   = meas_q;
        ovf_d    = ovf_q;
        riseHit  = sig_i & ~sig_q;
        fallHit  = ~sig_i & sig_q;
        edgeSeen = edgeHit(mode_q, riseHit, fallHit);
        cntInc   = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (kick_i) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                    mode_d  = edge_mode_t'(mode_i);
                end
            end
            S_ARMED: begin
                if (kick_i) begin
                    cnt_d  = '0;
                    mode_d = edge_mode_t'(mode_i);
                end else if (cntInc == CNT_MAX) begin
                    state_d = S_DONE;
                    meas_d  = CNT_MAX;
                    ovf_d   = 1'b1;
                end else if (edgeSeen) begin
                    state_d = S_DONE;
                    meas_d  = cntInc;
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            S_DONE: begin
                if (ack_i) begin
                    if (kick_i) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                        mode_d  = edge_mode_t'(mode_i);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, result and signal-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_RISE;
            cnt_q   <= '0;
            meas_q  <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            ovf_q   <= ovf_d;
            sig_q   <= sig_i;
        end
    end

    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q == S_ARMED);
    assign ovf_o   = ovf_q;
    assign meas_o  = meas_q;

endmodule

// File: rtl/edge_latency_meter.sv
// Multi-channel edge latency meter.
// Replicates one independent channel per monitored signal and packs the results.
module edge_latency_meter
    import edge_latency_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_i,
    input  logic [N_CH-1:0]       kick_i,
    input  logic [2*N_CH-1:0]     mode_i,
    input  logic [N_CH-1:0]       ack_i,
    output logic [N_CH-1:0]       valid_o,
    output logic [N_CH-1:0]       ovf_o,
    output logic [N_CH-1:0]       busy_o,
    output logic [CNT_W*N_CH-1:0] meas_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_latency_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (sig_i[i]),
            .kick_i  (kick_i[i]),
            .mode_i  (mode_i[2*i +: 2]),
            .ack_i   (ack_i[i]),
            .valid_o (valid_o[i]),
            .ovf_o   (ovf_o[i]),
            .busy_o  (busy_o[i]),
            .meas_o  (meas_o[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_latency_meter.sv
// Directed testbench for edge_latency_meter with two 4-bit channels.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_edge_latency_meter;

    localparam int N_CH  = 2;
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       sig_i;
    logic [N_CH-1:0]       kick_i;
    logic [2*N_CH-1:0]     mode_i;
    logic [N_CH-1:0]       ack_i;
    logic [N_CH-1:0]       valid_o;
    logic [N_CH-1:0]       ovf_o;
    logic [N_CH-1:0]       busy_o;
    logic [CNT_W*N_CH-1:0] meas_o;

    int checks;
    int failures;

    edge_latency_meter #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (sig_i),
        .kick_i  (kick_i),
        .mode_i  (mode_i),
        .ack_i   (ack_i),
        .valid_o (valid_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o),
        .meas_o  (meas_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance exactly one rising edge, landing on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Present kick/mode/ack for one rising edge, then drop the pulses.
    task automatic applyStimulus(input logic [1:0] k, input logic [3:0] m, input logic [1:0] a);
        kick_i = k;
        mode_i = m;
        ack_i  = a;
        @(negedge clk);
        kick_i = 2'b00;
        ack_i  = 2'b00;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({valid_o, ovf_o, busy_o, meas_o} !== 14'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {valid_o, ovf_o, busy_o, meas_o});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rise_latency();
        applyStimulus(2'b01, 4'b0000, 2'b00);
        repeat (4) tick();
        checks++;
        if (busy_o[0] !== 1'b1 || valid_o[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rise_busy: got busy=%b valid=%b expected busy=1 valid=0", busy_o[0], valid_o[0]);
        end
        sig_i[0] = 1'b1;
        tick();
        checks++;
        if (valid_o !== 2'b01 || meas_o[3:0] !== 4'd5 || ovf_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rise_result: got valid=%b meas=%0d ovf=%b busy=%b expected valid=01 meas=5 ovf=0 busy=0",
                     valid_o, meas_o[3:0], ovf_o[0], busy_o[0]);
        end
        applyStimulus(2'b00, 4'b0000, 2'b01);
        checks++;
        if (valid_o[0] !== 1'b0 || meas_o[3:0] !== 4'd5) begin
            failures++;
            $display("[TB] FAIL rise_ack: got valid=%b meas=%0d expected valid=0 meas=5", valid_o[0], meas_o[3:0]);
        end
    endtask

    task automatic test_dual_channel();
        applyStimulus(2'b11, 4'b1001, 2'b00);
        tick();
        tick();
        sig_i = 2'b10;
        tick();
        checks++;
        if (valid_o !== 2'b11 || meas_o !== 8'h33 || ovf_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dual_result: got valid=%b meas=%h ovf=%b expected valid=11 meas=33 ovf=00",
                     valid_o, meas_o, ovf_o);
        end
        applyStimulus(2'b00, 4'b0000, 2'b01);
        checks++;
        if (valid_o !== 2'b10) begin
            failures++;
            $display("[TB] FAIL dual_ack0: got valid=%b expected 10", valid_o);
        end
        applyStimulus(2'b00, 4'b0000, 2'b10);
    endtask

    task automatic test_timeout();
        applyStimulus(2'b01, 4'b0000, 2'b00);
        repeat (5) tick();
        applyStimulus(2'b00, 4'b0000, 2'b01);
        repeat (8) tick();
        checks++;
        if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_early: got valid=%b busy=%b expected valid=0 busy=1", valid_o[0], busy_o[0]);
        end
        tick();
        checks++;
        if (valid_o[0] !== 1'b1 || meas_o[3:0] !== 4'hF || ovf_o[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_result: got valid=%b meas=%h ovf=%b expected valid=1 meas=f ovf=1",
                     valid_o[0], meas_o[3:0], ovf_o[0]);
        end
        applyStimulus(2'b00, 4'b0000, 2'b01);
    endtask

    task automatic test_kick_edge_same_cycle();
        sig_i[0] = 1'b1;
        applyStimulus(2'b01, 4'b0000, 2'b00);
        tick();
        sig_i[0] = 1'b0;
        tick();
        tick();
        checks++;
        if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL same_cycle_ignored: got valid=%b busy=%b expected valid=0 busy=1", valid_o[0], busy_o[0]);
        end
        sig_i[0] = 1'b1;
        tick();
        checks++;
        if (valid_o[0] !== 1'b1 || meas_o[3:0] !== 4'd4 || ovf_o[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL same_cycle_result: got valid=%b meas=%0d ovf=%b expected valid=1 meas=4 ovf=0",
                     valid_o[0], meas_o[3:0], ovf_o[0]);
        end
        applyStimulus(2'b00, 4'b0000, 2'b01);
    endtask

    task automatic test_back_to_back();
        sig_i[0] = 1'b0;
        tick();
        applyStimulus(2'b01, 4'b0000, 2'b00);
        repeat (7) tick();
        applyStimulus(2'b01, 4'b0000, 2'b00);
        tick();
        sig_i[0] = 1'b1;
        tick();
        checks++;
        if (valid_o[0] !== 1'b1 || meas_o[3:0] !== 4'd2) begin
            failures++;
            $display("[TB] FAIL rekick_result: got valid=%b meas=%0d expected valid=1 meas=2", valid_o[0], meas_o[3:0]);
        end
        applyStimulus(2'b01, 4'b0001, 2'b00);
        checks++;
        if (valid_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || meas_o[3:0] !== 4'd2) begin
            failures++;
            $display("[TB] FAIL done_kick_ignored: got valid=%b busy=%b meas=%0d expected valid=1 busy=0 meas=2",
                     valid_o[0], busy_o[0], meas_o[3:0]);
        end
        applyStimulus(2'b01, 4'b0001, 2'b01);
        checks++;
        if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ack_kick_rearm: got valid=%b busy=%b expected valid=0 busy=1", valid_o[0], busy_o[0]);
        end
        tick();
        tick();
        sig_i[0] = 1'b0;
        tick();
        checks++;
        if (valid_o[0] !== 1'b1 || meas_o[3:0] !== 4'd3 || ovf_o[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rearm_result: got valid=%b meas=%0d ovf=%b expected valid=1 meas=3 ovf=0",
                     valid_o[0], meas_o[3:0], ovf_o[0]);
        end
        applyStimulus(2'b00, 4'b0000, 2'b01);
    endtask

    task automatic test_async_reset();
        applyStimulus(2'b10, 4'b1000, 2'b00);
        tick();
        checks++;
        if (busy_o[1] !== 1'b1 || meas_o !== 8'h33) begin
            failures++;
            $display("[TB] FAIL prereset_state: got busy=%b meas=%h expected busy=1 meas=33", busy_o[1], meas_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid_o, ovf_o, busy_o, meas_o} !== 14'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %h expected 0", {valid_o, ovf_o, busy_o, meas_o});
        end
        @(negedge clk);
        rst = 1'b0;
        sig_i[1] = ~sig_i[1];
        tick();
        tick();
        checks++;
        if (valid_o !== 2'b00 || busy_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got valid=%b busy=%b expected valid=00 busy=00", valid_o, busy_o);
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sig_i    = 2'b00;
        kick_i   = 2'b00;
        mode_i   = 4'b0000;
        ack_i    = 2'b00;
        $display("[TB] starting edge_latency_meter bench");
        test_reset();
        test_rise_latency();
        test_dual_channel();
        test_timeout();
        test_kick_edge_same_cycle();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
